resilient_ring_pipe: RTL and testbench

- Synchronous, parametrised successor to the bundled-data controller ring.
- Builds an N-stage half-buffer pipeline; every stage carries a WIDTH-bit token. The pipeline is either closed into a ring or run open with valid/ready ports.
- Each stage has a timing-error input. An error at capture holds that token for a programmable penalty before it may leave.
- Provides error and throughput counters and ring deadlock detection, for characterising resilient-pipeline behaviour in single-clock system models.

---
 rtl/resilient_ring_pipe.sv | 135 +++++++++++++
 tb/tb_resilient_ring_pipe.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/resilient_ring_pipe.sv
// rtl/resilient_ring_pipe.sv - N-stage half-buffer resilient pipeline, closed ring or open valid/ready
module resilient_ring_pipe #(
    parameter int                STAGES      = 3,
    parameter int                WIDTH       = 8,
    parameter int                RING        = 1,
    parameter logic [STAGES-1:0] TOKEN_MASK  = STAGES'(1),
    parameter int                ERR_PENALTY = 2,
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] err,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    input  logic              out_ready,
    output logic [STAGES-1:0] full,
    output logic [STAGES-1:0] sample,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  xfer_count,
    output logic              deadlock
);

    // Recovery counter load value; the stage sits one cycle in RECOVER per penalty cycle.
    localparam logic [3:0]        PEN_LD   = (ERR_PENALTY > 0) ? 4'(ERR_PENALTY - 1) : 4'd0;
    // Open pipelines always start empty, whatever the token mask says.
    localparam logic [STAGES-1:0] RST_MASK = (RING != 0) ? TOKEN_MASK : '0;
    // Sum width leaves headroom for every stage erroring in the same cycle.
    localparam int                SW       = CNT_W + $clog2(STAGES + 1);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FULL    = 2'd1,
        ST_RECOVER = 2'd2
    } stage_st_t;

    stage_st_t         st_q   [STAGES];
    stage_st_t         st_d   [STAGES];
    logic [3:0]        pcnt_q [STAGES];
    logic [3:0]        pcnt_d [STAGES];
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic [WIDTH-1:0]  src    [STAGES];
    logic [STAGES-1:0] mv;
    logic [STAGES-1:0] cap;
    logic [STAGES-1:0] full_d;
    logic [SW-1:0]     err_sum;
    logic [CNT_W-1:0]  err_count_d;

    assign in_ready  = (RING == 0) && (st_q[0] == ST_EMPTY);
    assign out_valid = (RING == 0) && (st_q[STAGES-1] == ST_FULL);
    assign out_data  = data_q[STAGES-1];

    // Moves are decided purely from start-of-cycle state, so nothing ripples combinationally.
    always_comb begin
        mv = '0;
        for (int i = 0; i < STAGES - 1; i++) begin
            mv[i] = (st_q[i] == ST_FULL) && (st_q[i+1] == ST_EMPTY);
        end
        if (RING != 0) begin
            mv[STAGES-1] = (st_q[STAGES-1] == ST_FULL) && (st_q[0] == ST_EMPTY);
        end else begin
            mv[STAGES-1] = out_valid && out_ready;
        end

        cap    = '0;
        cap[0] = (RING != 0) ? mv[STAGES-1] : (in_valid && in_ready);
        src[0] = (RING != 0) ? (data_q[STAGES-1] + WIDTH'(1)) : in_data;
        for (int i = 1; i < STAGES; i++) begin
            cap[i] = mv[i-1];
            src[i] = data_q[i-1];
        end
    end

    // Per-stage next state: capture, release, or count down a recovery penalty.
    always_comb begin
        err_sum = SW'(err_count);
        full_d  = '0;
        for (int i = 0; i < STAGES; i++) begin
            st_d[i]   = st_q[i];
            pcnt_d[i] = pcnt_q[i];
            data_d[i] = data_q[i];
            if (cap[i]) begin
                data_d[i] = src[i];
                if (err[i] && (ERR_PENALTY > 0)) begin
                    st_d[i]   = ST_RECOVER;
                    pcnt_d[i] = PEN_LD;
                end else begin
                    st_d[i] = ST_FULL;
                end
            end else if (mv[i]) begin
                st_d[i] = ST_EMPTY;
            end else if (st_q[i] == ST_RECOVER) begin
                if (pcnt_q[i] == 4'd0) begin
                    st_d[i] = ST_FULL;
                end else begin
                    pcnt_d[i] = pcnt_q[i] - 4'd1;
                end
            end
            err_sum   = err_sum + SW'(cap[i] & err[i]);
            full_d[i] = (st_d[i] != ST_EMPTY);
        end
        err_count_d = (|err_sum[SW-1:CNT_W]) ? '1 : err_sum[CNT_W-1:0];
    end

    // State, data and statistics registers; reset reloads the token pattern.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) begin
                st_q[i]   <= RST_MASK[i] ? ST_FULL : ST_EMPTY;
                pcnt_q[i] <= 4'd0;
                data_q[i] <= RST_MASK[i] ? WIDTH'(i) : '0;
            end
            full       <= RST_MASK;
            sample     <= '0;
            err_count  <= '0;
            xfer_count <= '0;
            deadlock   <= (RING != 0) && (&RST_MASK);
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                st_q[i]   <= st_d[i];
                pcnt_q[i] <= pcnt_d[i];
                data_q[i] <= data_d[i];
            end
            full       <= full_d;
            sample     <= cap;
            err_count  <= err_count_d;
            xfer_count <= xfer_count + CNT_W'(mv[STAGES-1]);
            deadlock   <= (RING != 0) && (&full_d);
        end
    end

endmodule

// File: tb/tb_resilient_ring_pipe.sv
// tb/tb_resilient_ring_pipe.sv - self-checking bench for resilient_ring_pipe
module tb_resilient_ring_pipe;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // ring, 3 stages, one token, penalty 2
    logic [2:0]  r_err;
    logic        r_iv, r_ir, r_ov, r_ordy, r_dl;
    logic [7:0]  r_id, r_od;
    logic [2:0]  r_full, r_sample;
    logic [15:0] r_errc, r_xfer;
    // ring, all stages loaded
    logic [2:0]  d_err;
    logic        d_iv, d_ir, d_ov, d_ordy, d_dl;
    logic [7:0]  d_id, d_od;
    logic [2:0]  d_full, d_sample;
    logic [15:0] d_errc, d_xfer;
    // open, 4 stages, penalty 2
    logic [3:0]  o_err;
    logic        o_iv, o_ir, o_ov, o_ordy, o_dl;
    logic [7:0]  o_id, o_od;
    logic [3:0]  o_full, o_sample;
    logic [15:0] o_errc, o_xfer;
    // ring, 4-bit counters, no penalty
    logic [2:0]  s_err;
    logic        s_iv, s_ir, s_ov, s_ordy, s_dl;
    logic [7:0]  s_id, s_od;
    logic [2:0]  s_full, s_sample;
    logic [3:0]  s_errc, s_xfer;

    resilient_ring_pipe #(.STAGES(3), .WIDTH(8), .RING(1), .TOKEN_MASK(3'b001), .ERR_PENALTY(2), .CNT_W(16)) u_ring (
        .clk(clk), .rst(rst), .err(r_err), .in_valid(r_iv), .in_data(r_id), .in_ready(r_ir),
        .out_valid(r_ov), .out_data(r_od), .out_ready(r_ordy), .full(r_full), .sample(r_sample),
        .err_count(r_errc), .xfer_count(r_xfer), .deadlock(r_dl));

    resilient_ring_pipe #(.STAGES(3), .WIDTH(8), .RING(1), .TOKEN_MASK(3'b111), .ERR_PENALTY(2), .CNT_W(16)) u_dead (
        .clk(clk), .rst(rst), .err(d_err), .in_valid(d_iv), .in_data(d_id), .in_ready(d_ir),
        .out_valid(d_ov), .out_data(d_od), .out_ready(d_ordy), .full(d_full), .sample(d_sample),
        .err_count(d_errc), .xfer_count(d_xfer), .deadlock(d_dl));

    resilient_ring_pipe #(.STAGES(4), .WIDTH(8), .RING(0), .TOKEN_MASK(4'b0101), .ERR_PENALTY(2), .CNT_W(16)) u_open (
        .clk(clk), .rst(rst), .err(o_err), .in_valid(o_iv), .in_data(o_id), .in_ready(o_ir),
        .out_valid(o_ov), .out_data(o_od), .out_ready(o_ordy), .full(o_full), .sample(o_sample),
        .err_count(o_errc), .xfer_count(o_xfer), .deadlock(o_dl));

    resilient_ring_pipe #(.STAGES(3), .WIDTH(8), .RING(1), .TOKEN_MASK(3'b001), .ERR_PENALTY(0), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .err(s_err), .in_valid(s_iv), .in_data(s_id), .in_ready(s_ir),
        .out_valid(s_ov), .out_data(s_od), .out_ready(s_ordy), .full(s_full), .sample(s_sample),
        .err_count(s_errc), .xfer_count(s_xfer), .deadlock(s_dl));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic idle_inputs();
        r_err = '0; r_iv = 1'b0; r_id = '0; r_ordy = 1'b0;
        d_err = '0; d_iv = 1'b0; d_id = '0; d_ordy = 1'b0;
        o_err = '0; o_iv = 1'b0; o_id = '0; o_ordy = 1'b0;
        s_err = '0; s_iv = 1'b0; s_id = '0; s_ordy = 1'b0;
    endtask

    // Reference model: each token carries the edge number from which it may leave.
    bit         m_full [4];
    logic [7:0] m_data [4];
    int         m_rdy  [4];
    int         m_edge, m_errs, m_xfer;
    logic [3:0] m_sample;

    task automatic model_reset(input int s, input bit ring, input logic [3:0] mask);
        for (int i = 0; i < 4; i++) begin
            m_full[i] = ring && (i < s) && mask[i];
            m_data[i] = m_full[i] ? 8'(i) : 8'd0;
            m_rdy[i]  = 1;
        end
        m_edge = 1; m_errs = 0; m_xfer = 0; m_sample = '0;
    endtask

    task automatic model_step(input int s, input bit ring, input int pen, input logic [3:0] e,
                              input bit iv, input logic [7:0] id, input bit ordy);
        bit         mv  [4];
        bit         cap [4];
        logic [7:0] nd  [4];
        bit         rdy;
        for (int i = 0; i < 4; i++) begin
            mv[i] = 1'b0; cap[i] = 1'b0; nd[i] = 8'd0;
        end
        for (int i = 0; i < s; i++) begin
            rdy = m_full[i] && (m_edge >= m_rdy[i]);
            if (i < s - 1)  mv[i] = rdy && !m_full[i+1];
            else if (ring)  mv[i] = rdy && !m_full[0];
            else            mv[i] = rdy && ordy;
        end
        cap[0] = ring ? mv[s-1] : (iv && !m_full[0]);
        nd[0]  = ring ? m_data[s-1] + 8'd1 : id;
        for (int i = 1; i < s; i++) begin
            cap[i] = mv[i-1];
            nd[i]  = m_data[i-1];
        end
        m_sample = '0;
        for (int i = 0; i < s; i++) begin
            if (mv[i]) m_full[i] = 1'b0;
            if (cap[i]) begin
                m_full[i]   = 1'b1;
                m_data[i]   = nd[i];
                m_rdy[i]    = m_edge + 1 + (e[i] ? pen : 0);
                m_sample[i] = 1'b1;
                if (e[i]) m_errs++;
            end
        end
        if (mv[s-1]) m_xfer++;
        m_edge++;
    endtask

    function automatic logic [3:0] model_full();
        logic [3:0] f;
        for (int i = 0; i < 4; i++) f[i] = m_full[i];
        return f;
    endfunction

    task automatic run_open(input string tag, input int n_tok, input logic [7:0] base, input int hold);
        logic [7:0] got[$];
        int  k = 0, cyc = 0, first_hs = -1, first_ov = -1, extra = 0;
        bit  hs, rel;
        idle_inputs();
        do_reset();
        while (got.size() < n_tok && cyc < 300) begin
            o_iv   = (k < n_tok);
            o_id   = base + 8'(k);
            o_ordy = (cyc >= hold);
            hs  = o_iv && o_ir;
            rel = o_ov && o_ordy;
            if (rel) got.push_back(o_od);
            if (hs) begin
                if (first_hs < 0) first_hs = cyc;
                k++;
            end
            tick();
            cyc++;
            if (o_ov && first_ov < 0) first_ov = cyc;
            if (hold > 0 && cyc == hold) begin
                check({tag, "_stall_in_ready"}, 32'(o_ir), 32'd0);
                check({tag, "_stall_full"}, 32'(o_full), 32'hF);
            end
        end
        o_iv   = 1'b0;
        o_ordy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (o_ov) extra++;
            tick();
        end
        o_ordy = 1'b0;
        check({tag, "_count"}, 32'(got.size()), 32'(n_tok));
        for (int j = 0; j < got.size(); j++) check({tag, "_data"}, 32'(got[j]), 32'(base + 8'(j)));
        check({tag, "_extra"}, 32'(extra), 32'd0);
        check({tag, "_xfer"}, 32'(o_xfer), 32'(n_tok));
        if (hold == 0) check({tag, "_latency"}, 32'(first_ov - first_hs), 32'd4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        idle_inputs();

        // ring: reset values and single-token circulation
        do_reset();
        check("ring_rst_full", 32'(r_full), 32'h1);
        check("ring_rst_sample", 32'(r_sample), 32'h0);
        check("ring_rst_errc", 32'(r_errc), 32'h0);
        check("ring_rst_xfer", 32'(r_xfer), 32'h0);
        check("ring_rst_dl", 32'(r_dl), 32'h0);
        check("ring_rst_in_ready", 32'(r_ir), 32'h0);
        check("ring_rst_out_valid", 32'(r_ov), 32'h0);
        check("ring_rst_out_data", 32'(r_od), 32'h0);
        tick();
        check("ring_e1_full", 32'(r_full), 32'h2);
        check("ring_e1_sample", 32'(r_sample), 32'h2);
        tick();
        check("ring_e2_full", 32'(r_full), 32'h4);
        tick();
        check("ring_e3_full", 32'(r_full), 32'h1);
        check("ring_e3_sample", 32'(r_sample), 32'h1);
        check("ring_e3_xfer", 32'(r_xfer), 32'h1);
        tick(); tick();
        check("ring_e5_out_data", 32'(r_od), 32'h1);
        tick(); tick(); tick();
        check("ring_e8_out_data", 32'(r_od), 32'h2);
        check("ring_e8_xfer", 32'(r_xfer), 32'h2);

        // ring: timing error at the first capture holds the token in stage 1
        do_reset();
        r_err = 3'b010;
        tick();
        r_err = 3'b000;
        check("err_e1_full", 32'(r_full), 32'h2);
        check("err_e1_sample", 32'(r_sample), 32'h2);
        check("err_e1_errc", 32'(r_errc), 32'h1);
        tick();
        check("err_e2_full", 32'(r_full), 32'h2);
        check("err_e2_sample", 32'(r_sample), 32'h0);
        tick();
        check("err_e3_full", 32'(r_full), 32'h2);
        tick();
        check("err_e4_full", 32'(r_full), 32'h4);
        check("err_e4_errc", 32'(r_errc), 32'h1);

        // fully loaded ring never moves
        d_err = 3'b111;
        do_reset();
        check("dead_rst_dl", 32'(d_dl), 32'h1);
        check("dead_rst_out_data", 32'(d_od), 32'h2);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("dead_dl", 32'(d_dl), 32'h1);
            check("dead_full", 32'(d_full), 32'h7);
        end
        check("dead_errc", 32'(d_errc), 32'h0);
        check("dead_xfer", 32'(d_xfer), 32'h0);
        check("dead_sample", 32'(d_sample), 32'h0);
        check("dead_in_ready", 32'(d_ir), 32'h0);
        check("dead_out_valid", 32'(d_ov), 32'h0);
        d_err = '0;

        // open pipeline: reset state, streaming, backpressure
        idle_inputs();
        do_reset();
        check("open_rst_full", 32'(o_full), 32'h0);
        check("open_rst_in_ready", 32'(o_ir), 32'h1);
        check("open_rst_out_valid", 32'(o_ov), 32'h0);
        check("open_rst_dl", 32'(o_dl), 32'h0);
        run_open("stream", 5, 8'hA0, 0);
        run_open("stall", 8, 8'hB0, 10);

        // randomized ring with timing errors against the model
        idle_inputs();
        do_reset();
        model_reset(3, 1'b1, 4'b0001);
        for (int c = 0; c < 200; c++) begin
            r_err = 3'($urandom);
            model_step(3, 1'b1, 2, {1'b0, r_err}, 1'b0, 8'd0, 1'b0);
            tick();
            check("rnd_ring_full", 32'(r_full), 32'(model_full() & 4'h7));
            check("rnd_ring_sample", 32'(r_sample), 32'(m_sample & 4'h7));
            check("rnd_ring_out_data", 32'(r_od), 32'(m_data[2]));
            check("rnd_ring_errc", 32'(r_errc), 32'(m_errs));
            check("rnd_ring_xfer", 32'(r_xfer), 32'(m_xfer));
        end
        r_err = '0;

        // randomized open pipeline with errors and backpressure against the model
        idle_inputs();
        do_reset();
        model_reset(4, 1'b0, 4'b0000);
        for (int c = 0; c < 300; c++) begin
            o_err  = 4'($urandom);
            o_iv   = 1'($urandom);
            o_id   = 8'($urandom);
            o_ordy = ($urandom_range(0, 3) != 0);
            model_step(4, 1'b0, 2, o_err, o_iv, o_id, o_ordy);
            tick();
            check("rnd_open_full", 32'(o_full), 32'(model_full()));
            check("rnd_open_sample", 32'(o_sample), 32'(m_sample));
            check("rnd_open_in_ready", 32'(o_ir), 32'(!m_full[0]));
            check("rnd_open_out_valid", 32'(o_ov), 32'(m_full[3] && (m_edge >= m_rdy[3])));
            check("rnd_open_out_data", 32'(o_od), 32'(m_data[3]));
            check("rnd_open_errc", 32'(o_errc), 32'(m_errs));
            check("rnd_open_xfer", 32'(o_xfer), 32'(m_xfer));
        end

        // saturating error counter, then asynchronous reset mid-traffic
        idle_inputs();
        s_err  = 3'b111;
        o_iv   = 1'b1;
        o_id   = 8'h5A;
        do_reset();
        check("sat_rst_out_data", 32'(s_od), 32'h0);
        check("sat_rst_in_ready", 32'(s_ir), 32'h0);
        check("sat_rst_out_valid", 32'(s_ov), 32'h0);
        check("sat_rst_dl", 32'(s_dl), 32'h0);
        for (int i = 0; i < 14; i++) tick();
        check("sat_errc_14", 32'(s_errc), 32'hE);
        for (int i = 0; i < 6; i++) tick();
        check("sat_errc_20", 32'(s_errc), 32'hF);
        check("sat_open_busy", 32'(o_full != 4'h0), 32'h1);
        #3;
        rst = 1'b0;
        #1;
        check("arst_errc", 32'(s_errc), 32'h0);
        check("arst_xfer", 32'(s_xfer), 32'h0);
        check("arst_full", 32'(s_full), 32'h1);
        check("arst_sample", 32'(s_sample), 32'h0);
        check("arst_open_full", 32'(o_full), 32'h0);
        check("arst_open_in_ready", 32'(o_ir), 32'h1);
        check("arst_open_xfer", 32'(o_xfer), 32'h0);
        check("arst_dead_dl", 32'(d_dl), 32'h1);
        check("arst_dead_full", 32'(d_full), 32'h7);
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
